id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core, directly downstream of the main decoder (opcode -> regdst/alusrc/memtoreg/regwrite/memread/memwrite/aluop).
- Latches decoder control bits plus ID-stage operands into EX.
- Contains the load-use hazard detector, which stalls PC and IF/ID and inserts bubbles.
- Keeps a saturating bubble counter for performance debug.

---
 rtl/id_ex_stage_pkg.sv | 30 +++
 rtl/id_ex_stage_if.sv | 38 +++
 rtl/id_ex_stage_hazard_detect.sv | 15 +
 rtl/id_ex_stage.sv | 95 +++++++++
 tb/tb_id_ex_stage.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared decoder/ID-EX types: ALU op classes, the 8-bit control bundle and its
// X-scrubbing helper.
package id_ex_stage_pkg;

  localparam logic [1:0] ALUOP_LW_SW = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;
  localparam logic [1:0] ALUOP_ADDI  = 2'b00;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Going through a 2-state vector turns every X/Z into 0, so a don't-care
  // from the decoder can never enable a write or a load downstream.
  function automatic ctrl_t ctrl_sanitize(input ctrl_t c);
    bit [$bits(ctrl_t)-1:0] b;
    b = c;
    return ctrl_t'(b);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX register; the stage is the
// slave, the decoder/ID stage plus EX consumers form the master.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
);
  logic              hold_i, flush_i;
  logic              regdst_i, alusrc_i, memtoreg_i, regwrite_i, memread_i, memwrite_i;
  logic [1:0]        aluop_i;
  logic [DATA_W-1:0] rs_data_i, rt_data_i, imm_i;
  logic [REG_W-1:0]  rs_i, rt_i, rd_i;
  logic [5:0]        funct_i;

  logic              regdst_o, alusrc_o, memtoreg_o, regwrite_o, memread_o, memwrite_o;
  logic [1:0]        aluop_o;
  logic [DATA_W-1:0] rs_data_o, rt_data_o, imm_o;
  logic [REG_W-1:0]  rs_o, rt_o, rd_o;
  logic [5:0]        funct_o;
  logic              valid_o, stall_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport slave (
    input  hold_i, flush_i, regdst_i, alusrc_i, memtoreg_i, regwrite_i, memread_i,
           memwrite_i, aluop_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i, funct_i,
    output regdst_o, alusrc_o, memtoreg_o, regwrite_o, memread_o, memwrite_o, aluop_o,
           rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o, funct_o, valid_o, stall_o,
           bubble_cnt_o
  );

  modport master (
    output hold_i, flush_i, regdst_i, alusrc_i, memtoreg_i, regwrite_i, memread_i,
           memwrite_i, aluop_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i, funct_i,
    input  regdst_o, alusrc_o, memtoreg_o, regwrite_o, memread_o, memwrite_o, aluop_o,
           rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o, funct_o, valid_o, stall_o,
           bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard: a valid load in EX whose destination is read by the
// instruction now in ID. $zero is never written, so rt==0 never hazards.
module id_ex_stage_hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_memread,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             haz
);
  assign haz = ex_memread & ex_valid & (ex_rt != '0) &
               ((ex_rt == id_rs) | (ex_rt == id_rt));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush/hold priority and a
// saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input logic         clk_i,
  input logic         rst_n_i,
  id_ex_stage_if.slave bus
);

  ctrl_t             ctrl_raw, ctrl_in, ctrl_q;
  logic              valid_q;
  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
  logic [REG_W-1:0]  rs_q, rt_q, rd_q;
  logic [5:0]        funct_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              haz;

  assign ctrl_raw = {bus.regdst_i, bus.alusrc_i, bus.memtoreg_i, bus.regwrite_i,
                     bus.memread_i, bus.memwrite_i, bus.aluop_i};
  assign ctrl_in  = ctrl_sanitize(ctrl_raw);

  id_ex_stage_hazard_detect #(.REG_W(REG_W)) u_haz (
    .ex_memread (ctrl_q.memread),
    .ex_valid   (valid_q),
    .ex_rt      (rt_q),
    .id_rs      (bus.rs_i),
    .id_rt      (bus.rt_i),
    .haz        (haz)
  );

  // A flush already discards the ID instruction, and hold freezes PC/IF/ID
  // anyway, so the stall request is only needed for a bare hazard.
  assign bus.stall_o = haz & ~bus.flush_i & ~bus.hold_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_q    <= CTRL_NOP;
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      funct_q   <= '0;
      cnt_q     <= '0;
    end else if (bus.hold_i) begin
      cnt_q <= cnt_q;
    end else if (bus.flush_i || haz) begin
      ctrl_q    <= CTRL_NOP;
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      funct_q   <= '0;
      if (!(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      ctrl_q    <= ctrl_in;
      valid_q   <= 1'b1;
      rs_data_q <= bus.rs_data_i;
      rt_data_q <= bus.rt_data_i;
      imm_q     <= bus.imm_i;
      rs_q      <= bus.rs_i;
      rt_q      <= bus.rt_i;
      rd_q      <= bus.rd_i;
      funct_q   <= bus.funct_i;
    end
  end

  assign bus.regdst_o     = ctrl_q.regdst;
  assign bus.alusrc_o     = ctrl_q.alusrc;
  assign bus.memtoreg_o   = ctrl_q.memtoreg;
  assign bus.regwrite_o   = ctrl_q.regwrite;
  assign bus.memread_o    = ctrl_q.memread;
  assign bus.memwrite_o   = ctrl_q.memwrite;
  assign bus.aluop_o      = ctrl_q.aluop;
  assign bus.rs_data_o    = rs_data_q;
  assign bus.rt_data_o    = rt_data_q;
  assign bus.imm_o        = imm_q;
  assign bus.rs_o         = rs_q;
  assign bus.rt_o         = rt_q;
  assign bus.rd_o         = rd_q;
  assign bus.funct_o      = funct_q;
  assign bus.valid_o      = valid_q;
  assign bus.bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues expected stall/EX state
// per cycle, a monitor pops and compares.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 16;
  localparam int OUT_W  = 8 + 1 + 3*DATA_W + 3*REG_W + 6 + CNT_W;

  localparam logic [7:0] C_RT    = 8'b1001_0011;
  localparam logic [7:0] C_LW    = 8'b0111_1000;
  localparam logic [7:0] C_SW_X  = 8'bx1x0_0100;
  localparam logic [7:0] C_SW    = 8'b0100_0100;
  localparam logic [7:0] C_MR_X  = 8'b1001_x011;
  localparam logic [7:0] C_MR    = 8'b1001_0011;

  typedef enum {K_LATCH, K_BUBBLE, K_HOLD} kind_e;

  typedef struct {
    string             name;
    logic              stall;
    logic [7:0]        ctrl;
    logic              valid;
    logic [DATA_W-1:0] rs_d, rt_d, imm;
    logic [REG_W-1:0]  rs, rt, rd;
    logic [5:0]        funct;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b1;

  id_ex_stage_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus();

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  exp_t             q[$];
  exp_t             last;
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  function automatic logic [OUT_W-1:0] pack_exp(input exp_t e);
    return {e.ctrl, e.valid, e.rs_d, e.rt_d, e.imm, e.rs, e.rt, e.rd, e.funct, e.cnt};
  endfunction

  function automatic logic [OUT_W-1:0] pack_act();
    return {bus.regdst_o, bus.alusrc_o, bus.memtoreg_o, bus.regwrite_o, bus.memread_o,
            bus.memwrite_o, bus.aluop_o, bus.valid_o, bus.rs_data_o, bus.rt_data_o,
            bus.imm_o, bus.rs_o, bus.rt_o, bus.rd_o, bus.funct_o, bus.bubble_cnt_o};
  endfunction

  task automatic chk_out(input string name, input exp_t e);
    logic [OUT_W-1:0] a;
    a = pack_act();
    n_cmp++;
    if (a !== pack_exp(e)) begin
      n_bad++;
      $display("FAIL %s outputs: got %h want %h", name, a, pack_exp(e));
    end
  endtask

  task automatic chk_stall(input string name, input logic want);
    n_cmp++;
    if (bus.stall_o !== want) begin
      n_bad++;
      $display("FAIL %s stall_o: got %b want %b", name, bus.stall_o, want);
    end
  endtask

  function automatic exp_t zero_exp(input string name);
    exp_t e;
    e.name = name; e.stall = 1'b0; e.ctrl = '0; e.valid = 1'b0;
    e.rs_d = '0; e.rt_d = '0; e.imm = '0; e.rs = '0; e.rt = '0; e.rd = '0;
    e.funct = '0; e.cnt = '0;
    return e;
  endfunction

  task automatic drive(input logic [7:0] c, input logic [DATA_W-1:0] rsd, rtd, imm,
                       input logic [REG_W-1:0] rs, rt, rd, input logic [5:0] fn,
                       input logic hold, flush);
    {bus.regdst_i, bus.alusrc_i, bus.memtoreg_i, bus.regwrite_i,
     bus.memread_i, bus.memwrite_i, bus.aluop_i} = c;
    bus.rs_data_i = rsd; bus.rt_data_i = rtd; bus.imm_i = imm;
    bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd; bus.funct_i = fn;
    bus.hold_i = hold; bus.flush_i = flush;
  endtask

  // One ID cycle: drive at the falling edge, queue the stall expected before
  // the next rising edge and the EX state expected after it.
  task automatic step(input string name, input logic [7:0] c, exp_c,
                      input logic [DATA_W-1:0] rsd, rtd, imm,
                      input logic [REG_W-1:0] rs, rt, rd, input logic [5:0] fn,
                      input logic hold, flush, exp_stall, input kind_e k);
    exp_t e;
    @(negedge clk_i);
    drive(c, rsd, rtd, imm, rs, rt, rd, fn, hold, flush);
    case (k)
      K_LATCH: begin
        e = zero_exp(name);
        e.ctrl = exp_c; e.valid = 1'b1;
        e.rs_d = rsd; e.rt_d = rtd; e.imm = imm;
        e.rs = rs; e.rt = rt; e.rd = rd; e.funct = fn; e.cnt = exp_cnt;
      end
      K_BUBBLE: begin
        if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        e = zero_exp(name);
        e.cnt = exp_cnt;
      end
      default: begin
        e = last;
        e.name = name;
      end
    endcase
    e.stall = exp_stall;
    last = e;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_stall(e.name, e.stall);
        @(posedge clk_i);
        #1;
        chk_out(e.name, e);
      end
    end
  end

  initial begin : driver
    drive(8'h00, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    #1 rst_n_i = 1'b0;
    @(posedge clk_i); #2;
    chk_out("reset", zero_exp("reset"));
    chk_stall("reset", 1'b0);
    last = zero_exp("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // normal latch and single load-use stall
    step("rtype",      C_RT, C_RT, 32'h5, 32'h3, 32'h0, 5'd1, 5'd2, 5'd8, 6'h20, 0, 0, 0, K_LATCH);
    step("lw9",        C_LW, C_LW, 32'h64, 32'h0, 32'h4, 5'd3, 5'd9, 5'd0, 6'h00, 0, 0, 0, K_LATCH);
    step("lu_stall",   C_RT, C_RT, 32'h7, 32'h8, 32'h0, 5'd9, 5'd4, 5'd10, 6'h20, 0, 0, 1, K_BUBBLE);
    step("lu_resume",  C_RT, C_RT, 32'h7, 32'h8, 32'h0, 5'd9, 5'd4, 5'd10, 6'h20, 0, 0, 0, K_LATCH);
    // no false hazards
    step("lw0",        C_LW, C_LW, 32'h64, 32'h0, 32'h8, 5'd3, 5'd0, 5'd0, 6'h00, 0, 0, 0, K_LATCH);
    step("rs0_nohaz",  C_RT, C_RT, 32'h1, 32'h2, 32'h0, 5'd0, 5'd0, 5'd11, 6'h20, 0, 0, 0, K_LATCH);
    step("lw9b",       C_LW, C_LW, 32'h64, 32'h0, 32'hC, 5'd3, 5'd9, 5'd0, 6'h00, 0, 0, 0, K_LATCH);
    step("rs10_nohaz", C_RT, C_RT, 32'h1, 32'h2, 32'h0, 5'd10, 5'd11, 5'd12, 6'h20, 0, 0, 0, K_LATCH);
    // back-to-back dependent loads, second dependence through rt
    step("lw9c",       C_LW, C_LW, 32'h64, 32'h0, 32'h10, 5'd3, 5'd9, 5'd0, 6'h00, 0, 0, 0, K_LATCH);
    step("lw_dep",     C_LW, C_LW, 32'hC8, 32'h0, 32'h10, 5'd9, 5'd12, 5'd0, 6'h00, 0, 0, 1, K_BUBBLE);
    step("lw_dep_go",  C_LW, C_LW, 32'hC8, 32'h0, 32'h10, 5'd9, 5'd12, 5'd0, 6'h00, 0, 0, 0, K_LATCH);
    step("rt_dep",     C_RT, C_RT, 32'h5, 32'h6, 32'h0, 5'd13, 5'd12, 5'd14, 6'h22, 0, 0, 1, K_BUBBLE);
    step("rt_dep_go",  C_RT, C_RT, 32'h5, 32'h6, 32'h0, 5'd13, 5'd12, 5'd14, 6'h22, 0, 0, 0, K_LATCH);
    // flush beats hazard
    step("lw9d",       C_LW, C_LW, 32'h64, 32'h0, 32'h14, 5'd3, 5'd9, 5'd0, 6'h00, 0, 0, 0, K_LATCH);
    step("flush_haz",  C_RT, C_RT, 32'h7, 32'h8, 32'h0, 5'd9, 5'd4, 5'd10, 6'h20, 0, 1, 0, K_BUBBLE);
    step("post_flush", C_RT, C_RT, 32'h7, 32'h8, 32'h0, 5'd9, 5'd4, 5'd10, 6'h20, 0, 0, 0, K_LATCH);
    // hold during an active hazard
    step("lw9e",       C_LW, C_LW, 32'h64, 32'h0, 32'h18, 5'd3, 5'd9, 5'd0, 6'h00, 0, 0, 0, K_LATCH);
    step("hold1",      C_RT, C_RT, 32'h7, 32'h8, 32'h0, 5'd9, 5'd4, 5'd10, 6'h20, 1, 0, 0, K_HOLD);
    step("hold2",      C_LW, C_LW, 32'hAA, 32'hBB, 32'h1, 5'd9, 5'd5, 5'd6, 6'h01, 1, 1, 0, K_HOLD);
    step("hold3",      C_RT, C_RT, 32'hCC, 32'hDD, 32'h2, 5'd1, 5'd9, 5'd7, 6'h2A, 1, 0, 0, K_HOLD);
    step("hold_rel",   C_RT, C_RT, 32'h7, 32'h8, 32'h0, 5'd9, 5'd4, 5'd10, 6'h20, 0, 0, 1, K_BUBBLE);
    step("hold_go",    C_RT, C_RT, 32'h7, 32'h8, 32'h0, 5'd9, 5'd4, 5'd10, 6'h20, 0, 0, 0, K_LATCH);
    // X scrubbing; a scrubbed memread must not create a hazard
    step("sw_x",       C_SW_X, C_SW, 32'h9, 32'hA, 32'h14, 5'd9, 5'd10, 5'd0, 6'h00, 0, 0, 0, K_LATCH);
    step("memread_x",  C_MR_X, C_MR, 32'h1, 32'h2, 32'h0, 5'd1, 5'd7, 5'd8, 6'h20, 0, 0, 0, K_LATCH);
    step("mr_x_next",  C_RT, C_RT, 32'h3, 32'h4, 32'h0, 5'd7, 5'd7, 5'd9, 6'h20, 0, 0, 0, K_LATCH);
    // counter saturation
    while (exp_cnt != '1)
      step("sat_flush", C_RT, C_RT, 32'h1, 32'h1, 32'h0, 5'd1, 5'd1, 5'd1, 6'h20, 0, 1, 0, K_BUBBLE);
    repeat (3)
      step("sat_max",   C_RT, C_RT, 32'h1, 32'h1, 32'h0, 5'd1, 5'd1, 5'd1, 6'h20, 0, 1, 0, K_BUBBLE);
    step("post_sat",   C_RT, C_RT, 32'h2, 32'h3, 32'h0, 5'd2, 5'd3, 5'd4, 6'h20, 0, 0, 0, K_LATCH);
    // reset in the middle of a stall
    step("lw9f",       C_LW, C_LW, 32'h64, 32'h0, 32'h1C, 5'd3, 5'd9, 5'd0, 6'h00, 0, 0, 0, K_LATCH);
    @(negedge clk_i);
    drive(C_RT, 32'h7, 32'h8, 32'h0, 5'd9, 5'd4, 5'd10, 6'h20, 1'b0, 1'b0);
    #2;
    chk_stall("mid_stall", 1'b1);
    rst_n_i = 1'b0;
    #1;
    chk_stall("rst_mid_stall", 1'b0);
    chk_out("rst_mid_stall", zero_exp("rst_mid_stall"));
    repeat (2) @(posedge clk_i);
    #1;
    chk_out("rst_held", zero_exp("rst_held"));

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
